fm_wb_collector: RTL and testbench
==================================

Name: fm_wb_collector

Overview:
- Sits directly downstream of the PE matrix output stage.
- Consumes the per-PE-row 8-bit write-back bytes, 6-bit guard words and finish strobes that the matrix produces with no backpressure.
- Packs bytes into buffer words, absorbs bursts in per-row FIFOs and round-robin arbitrates all rows onto a single feature-map buffer write port and a single guard buffer write port.
- Generates write addresses and signals layer completion to the top-level controller.

Parameters:
ROWS, CONF_PE_ROW, number of PE rows served
PACK, 4, bytes per feature-map buffer word
FIFO_DEPTH, 8, words per row FIFO (power of two)
ADDR_W, 12, buffer address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse; latches base addresses, begins a layer
fm_base_i  in  ADDR_W  feature-map word address of row 0
guard_base_i  in  ADDR_W  guard address of row 0
row_stride_i  in  ADDR_W  address offset between consecutive rows (both buffers)
wb_data_i  in  ROWS*8  per-row result byte
wb_valid_i  in  ROWS  per-row byte valid
wb_finish_i  in  ROWS  per-row end-of-layer strobe
guard_i  in  ROWS*6  per-row guard word
guard_valid_i  in  ROWS  per-row guard valid
fm_wr_en_o  out  1  feature-map buffer write enable
fm_wr_addr_o  out  ADDR_W  feature-map write address
fm_wr_data_o  out  PACK*8  packed word; byte 0 in LSBs
guard_wr_en_o  out  1  guard buffer write enable
guard_wr_addr_o  out  ADDR_W  guard write address
guard_wr_data_o  out  6  guard word
busy_o  out  1  high outside IDLE
done_o  out  1  one-cycle pulse at layer end
overflow_o  out  1  sticky; data lost
overflow_row_o  out  ROWS  sticky per-row loss flags

Behaviour:
- Reset: all outputs 0, FSM IDLE, packers, FIFOs, counters and holding regs cleared. Reset asserted mid-layer discards all pending data with no write.
- FSM is IDLE -> RUN -> DRAIN -> DONE -> IDLE:
  - IDLE -> RUN on start_i; latches fm_base_i, guard_base_i, row_stride_i and clears per-row word/guard counters and the finish mask.
  - RUN -> DRAIN when all ROWS finish-mask bits are set.
  - DRAIN -> DONE when every packer is empty, every FIFO is empty and every guard holding reg is empty.
  - DONE lasts one cycle: done_o=1, then IDLE. start_i outside IDLE is ignored.
- Inputs arriving in IDLE are ignored; they do not set overflow.
- Packer (per row):
  - Byte counter 0..PACK-1; wb_valid_i writes the byte at lane = counter.
  - Reaching PACK pushes the word to the row FIFO next cycle.
  - wb_finish_i sets the mask bit. A partial word is zero-padded in the upper lanes and pushed.
  - Byte and finish in the same cycle: the byte is included before the flush.
- FIFO full at push: word dropped; overflow_o and overflow_row_o[r] set.
- FM arbiter: round-robin over non-empty FIFOs, pointer starts at row 0 and advances to the row after the grantee.
  - One pop per cycle, registered outputs, so a push-to-write latency of 1 cycle minimum.
  - fm_wr_addr_o = fm_base + r*row_stride + fm_cnt[r], computed modulo 2^ADDR_W; fm_cnt[r] increments per write.
- Guard path (per row): 1-deep holding reg; separate round-robin arbiter with an identical policy.
  - guard_wr_addr_o = guard_base + r*row_stride + g_cnt[r].
  - guard_valid_i while the holding reg is full and not granted in that cycle: guard dropped, overflow flags set.
  - Grant and new valid in the same cycle: the reg is replaced with no loss.
- Counters wrap modulo 2^ADDR_W silently.

Optional Feature:
- FM_WB_PERF_CNT_EN defined:
  - Adds port stall_cnt_o (out, 16) counting cycles in RUN/DRAIN where ≥2 FIFOs are non-empty. Saturates at 0xFFFF, clears on start_i, reset 0.
  - Adds port words_cnt_o (out, 16) counting fm writes.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- diff_demo_pkg gets typedef fm_wb_state_t (IDLE, RUN, DRAIN, DONE) and constants FM_WB_PACK and FM_WB_FIFO_DEPTH.
- Sub-module fm_wb_row_packer (packer + FIFO + fm_cnt for one row), instantiated ROWS times.
- Arbiters and FSM stay in the top.

Test Plan:
1. ROWS=2, base 0x100, stride 0x40; row 0 sends bytes 01..08 then finish, row 1 sends finish only -> writes 0x04030201@0x100, 0x08070605@0x101; done_o pulses once; no row 1 writes.
2. Row 1 sends 3 bytes AA,BB,CC then finish in the same cycle as CC -> single write 0x00CCBBAA@base+stride.
3. Both rows push a full word every cycle for 20 words, FIFO_DEPTH=8 -> writes alternate rows 0,1,0,1; overflow_row_o=2'b11 once FIFOs fill; lost word count matches model.
4. guard_valid_i on all rows in the same cycle with values 0x01..0x0N -> N guard writes over N cycles in row order 0..N-1, addresses guard_base+r*stride, no overflow.
5. Reset pulsed mid-RUN with 3 words queued -> no further writes, all outputs 0, busy_o=0; next start_i runs cleanly with counters at 0.
6. start_i re-pulsed during DRAIN -> ignored; base addresses unchanged; single done_o.

Source files
------------

// File: rtl/diff_demo_pkg.sv
// Shared types and constants for the feature-map write-back collector.
//   fm_wb_state_t    : collector FSM states (IDLE, RUN, DRAIN, DONE)
//   FM_WB_PACK       : default bytes per feature-map buffer word
//   FM_WB_FIFO_DEPTH : default words per row FIFO
package diff_demo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fm_wb_state_t;

    localparam int FM_WB_PACK       = 4;
    localparam int FM_WB_FIFO_DEPTH = 8;

endpackage

// File: rtl/fm_wb_row_packer.sv
// One PE row of the write-back collector: byte packer, staging register,
// word FIFO and the row's feature-map write counter.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear_i           start of a layer: empties everything, zeroes fm_cnt
//   en_i              collector active (inputs ignored when low)
//   data_i/valid_i    result byte and its valid
//   finish_i          end-of-layer strobe, flushes a partial word
//   pop_i             arbiter grant for this row (FIFO pop)
//   head_o, empty_o   FIFO head word and empty flag
//   idle_o            packer, staging register and FIFO all empty
//   drop_o            staged word lost to a full FIFO this cycle
//   fm_cnt_o          number of words written for this row
module fm_wb_row_packer #(
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [7:0]        data_i,
    input  logic              valid_i,
    input  logic              finish_i,
    input  logic              pop_i,
    output logic [PACK*8-1:0] head_o,
    output logic              empty_o,
    output logic              idle_o,
    output logic              drop_o,
    output logic [ADDR_W-1:0] fm_cnt_o
);
    localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CW-1:0]      cnt_q;
    logic [PACK*8-1:0]  word_q;
    logic [PACK*8-1:0]  word_d;
    logic [PACK*8-1:0]  stage_q;
    logic               stage_v_q;
    logic [PACK*8-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [PW:0]        count_q;
    logic [ADDR_W-1:0]  fm_cnt_q;
    logic               take;
    logic               flush;
    logic               full;
    logic               do_pop;
    logic               do_push;

    // The incoming byte is merged before the flush decision so a byte and
    // finish in the same cycle land in the flushed word.
    always_comb begin
        take   = en_i && valid_i;
        word_d = word_q;
        for (int l = 0; l < PACK; l++) begin
            if (take && (cnt_q == CW'(l))) begin
                word_d[l*8 +: 8] = data_i;
            end
        end
        flush = (take && (cnt_q == CW'(PACK - 1))) ||
                (en_i && finish_i && (take || (cnt_q != '0)));
    end

    assign empty_o  = (count_q == '0);
    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign do_pop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the staged word needs.
    assign do_push  = stage_v_q && (!full || do_pop);
    assign drop_o   = stage_v_q && full && !do_pop;
    assign head_o   = mem_q[rd_ptr_q];
    assign idle_o   = (cnt_q == '0) && !stage_v_q && empty_o;
    assign fm_cnt_o = fm_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            word_q    <= '0;
            stage_q   <= '0;
            stage_v_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fm_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            cnt_q     <= '0;
            word_q    <= '0;
            stage_v_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fm_cnt_q  <= '0;
        end else begin
            // Upper lanes of word_q stay zero after a flush, which is what
            // zero-pads a partial word.
            if (flush) begin
                stage_q   <= word_d;
                stage_v_q <= 1'b1;
                word_q    <= '0;
                cnt_q     <= '0;
            end else begin
                stage_v_q <= 1'b0;
                if (take) begin
                    word_q <= word_d;
                    cnt_q  <= cnt_q + CW'(1);
                end
            end

            if (do_push) begin
                mem_q[wr_ptr_q] <= stage_q;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                fm_cnt_q <= fm_cnt_q + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fm_wb_collector.sv
// Feature-map write-back collector. Packs per-row result bytes into buffer
// words, queues them per row and round-robin arbitrates all rows onto one
// feature-map write port; guard words take a parallel 1-deep-per-row path
// onto one guard write port. Signals layer completion with done_o.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start_i                          begin a layer (honoured in IDLE only)
//   fm_base_i/guard_base_i           row-0 base addresses, latched on start
//   row_stride_i                     per-row address offset, latched on start
//   wb_data_i/wb_valid_i/wb_finish_i per-row bytes, valids, finish strobes
//   guard_i/guard_valid_i            per-row guard words and valids
//   fm_wr_*_o, guard_wr_*_o          buffer write ports (registered)
//   busy_o, done_o                   status: not IDLE / one-cycle layer end
//   overflow_o, overflow_row_o       sticky data-loss flags
// Optional build macro FM_WB_PERF_CNT_EN adds stall_cnt_o and words_cnt_o.
module fm_wb_collector
    import diff_demo_pkg::*;
#(
    parameter int ROWS       = 2,   // CONF_PE_ROW of the enclosing array
    parameter int PACK       = FM_WB_PACK,
    parameter int FIFO_DEPTH = FM_WB_FIFO_DEPTH,
    parameter int ADDR_W     = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   fm_base_i,
    input  logic [ADDR_W-1:0]   guard_base_i,
    input  logic [ADDR_W-1:0]   row_stride_i,
    input  logic [ROWS*8-1:0]   wb_data_i,
    input  logic [ROWS-1:0]     wb_valid_i,
    input  logic [ROWS-1:0]     wb_finish_i,
    input  logic [ROWS*6-1:0]   guard_i,
    input  logic [ROWS-1:0]     guard_valid_i,
    output logic                fm_wr_en_o,
    output logic [ADDR_W-1:0]   fm_wr_addr_o,
    output logic [PACK*8-1:0]   fm_wr_data_o,
    output logic                guard_wr_en_o,
    output logic [ADDR_W-1:0]   guard_wr_addr_o,
    output logic [5:0]          guard_wr_data_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                overflow_o,
    output logic [ROWS-1:0]     overflow_row_o
`ifdef FM_WB_PERF_CNT_EN
    ,
    output logic [15:0]         stall_cnt_o,
    output logic [15:0]         words_cnt_o
`endif
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    fm_wb_state_t       state_q;
    logic               busy_q;
    logic               done_q;
    logic [ADDR_W-1:0]  fm_base_q;
    logic [ADDR_W-1:0]  guard_base_q;
    logic [ADDR_W-1:0]  stride_q;
    logic [ROWS-1:0]    fin_mask_q;
    logic               active;
    logic               start_go;
    logic               all_idle;

    logic [PACK*8-1:0]  head [ROWS];
    logic [ADDR_W-1:0]  fm_cnt [ROWS];
    logic [ROWS-1:0]    fifo_empty;
    logic [ROWS-1:0]    pk_idle;
    logic [ROWS-1:0]    pk_drop;
    logic [ROWS-1:0]    fm_pop;

    logic [5:0]         ghold_q [ROWS];
    logic [ROWS-1:0]    ghold_v_q;
    logic [ADDR_W-1:0]  g_cnt_q [ROWS];
    logic [ROWS-1:0]    g_grant;
    logic [ROWS-1:0]    gdrop;

    logic [RW-1:0]      fm_ptr_q;
    logic [RW-1:0]      g_ptr_q;
    logic               fm_vld;
    logic [RW-1:0]      fm_idx;
    logic               g_vld;
    logic [RW-1:0]      g_idx;

    logic               fm_wr_en_q;
    logic [ADDR_W-1:0]  fm_wr_addr_q;
    logic [PACK*8-1:0]  fm_wr_data_q;
    logic               guard_wr_en_q;
    logic [ADDR_W-1:0]  guard_wr_addr_q;
    logic [5:0]         guard_wr_data_q;
    logic               ovf_q;
    logic [ROWS-1:0]    ovf_row_q;

    // First requester at or after ptr, wrapping; returns {found, index}.
    function automatic logic [RW:0] rr_pick(input logic [ROWS-1:0] req,
                                            input logic [RW-1:0]   ptr);
        logic          found;
        logic [RW-1:0] pick;
        int            idx;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < ROWS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= ROWS) idx = idx - ROWS;
            for (int j = 0; j < ROWS; j++) begin
                if (!found && (j == idx) && req[j]) begin
                    found = 1'b1;
                    pick  = RW'(j);
                end
            end
        end
        return {found, pick};
    endfunction

    function automatic logic [RW-1:0] rr_next(input logic [RW-1:0] idx);
        return (int'(idx) == ROWS - 1) ? '0 : idx + RW'(1);
    endfunction

    assign active   = (state_q != IDLE);
    assign start_go = start_i && (state_q == IDLE);
    assign all_idle = (&pk_idle) && !(|ghold_v_q);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        fm_wb_row_packer #(
            .PACK       (PACK),
            .FIFO_DEPTH (FIFO_DEPTH),
            .ADDR_W     (ADDR_W)
        ) u_packer (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear_i  (start_go),
            .en_i     (active),
            .data_i   (wb_data_i[r*8 +: 8]),
            .valid_i  (wb_valid_i[r]),
            .finish_i (wb_finish_i[r]),
            .pop_i    (fm_pop[r]),
            .head_o   (head[r]),
            .empty_o  (fifo_empty[r]),
            .idle_o   (pk_idle[r]),
            .drop_o   (pk_drop[r]),
            .fm_cnt_o (fm_cnt[r])
        );
    end

    always_comb begin
        {fm_vld, fm_idx} = rr_pick(~fifo_empty, fm_ptr_q);
        {g_vld, g_idx}   = rr_pick(ghold_v_q, g_ptr_q);
        fm_pop  = '0;
        g_grant = '0;
        gdrop   = '0;
        for (int r = 0; r < ROWS; r++) begin
            fm_pop[r]  = fm_vld && (fm_idx == RW'(r));
            g_grant[r] = g_vld && (g_idx == RW'(r));
            // A granted holding reg frees up this cycle, so a new guard
            // simply replaces it.
            gdrop[r]   = active && guard_valid_i[r] && ghold_v_q[r] && !g_grant[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fm_base_q    <= '0;
            guard_base_q <= '0;
            stride_q     <= '0;
            fin_mask_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        fm_base_q    <= fm_base_i;
                        guard_base_q <= guard_base_i;
                        stride_q     <= row_stride_i;
                        fin_mask_q   <= '0;
                    end
                end
                RUN: begin
                    fin_mask_q <= fin_mask_q | wb_finish_i;
                    if (&fin_mask_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (all_idle) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_ptr_q        <= '0;
            g_ptr_q         <= '0;
            fm_wr_en_q      <= 1'b0;
            fm_wr_addr_q    <= '0;
            fm_wr_data_q    <= '0;
            guard_wr_en_q   <= 1'b0;
            guard_wr_addr_q <= '0;
            guard_wr_data_q <= '0;
            ghold_v_q       <= '0;
            ovf_q           <= 1'b0;
            ovf_row_q       <= '0;
            for (int r = 0; r < ROWS; r++) begin
                ghold_q[r] <= '0;
                g_cnt_q[r] <= '0;
            end
        end else begin
            fm_wr_en_q    <= fm_vld;
            guard_wr_en_q <= g_vld;
            if (fm_vld) begin
                fm_wr_addr_q <= fm_base_q + ADDR_W'(fm_idx) * stride_q + fm_cnt[fm_idx];
                fm_wr_data_q <= head[fm_idx];
                fm_ptr_q     <= rr_next(fm_idx);
            end
            if (g_vld) begin
                guard_wr_addr_q <= guard_base_q + ADDR_W'(g_idx) * stride_q + g_cnt_q[g_idx];
                guard_wr_data_q <= ghold_q[g_idx];
                g_ptr_q         <= rr_next(g_idx);
            end
            for (int r = 0; r < ROWS; r++) begin
                if (active && guard_valid_i[r] && (!ghold_v_q[r] || g_grant[r])) begin
                    ghold_q[r]   <= guard_i[r*6 +: 6];
                    ghold_v_q[r] <= 1'b1;
                end else if (g_grant[r]) begin
                    ghold_v_q[r] <= 1'b0;
                end
                if (g_grant[r]) g_cnt_q[r] <= g_cnt_q[r] + ADDR_W'(1);
            end
            ovf_row_q <= ovf_row_q | pk_drop | gdrop;
            ovf_q     <= ovf_q | (|(pk_drop | gdrop));
            // Each layer arbitrates from row 0 with fresh guard counters.
            if (start_go) begin
                fm_ptr_q  <= '0;
                g_ptr_q   <= '0;
                ghold_v_q <= '0;
                for (int r = 0; r < ROWS; r++) begin
                    g_cnt_q[r] <= '0;
                end
            end
        end
    end

`ifdef FM_WB_PERF_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] words_q;
    logic        multi;

    always_comb begin
        int n;
        n = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (!fifo_empty[r]) n = n + 1;
        end
        multi = (n >= 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            words_q <= '0;
        end else if (start_go) begin
            stall_q <= '0;
            words_q <= '0;
        end else begin
            if (((state_q == RUN) || (state_q == DRAIN)) && multi && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (fm_vld) words_q <= words_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
    assign words_cnt_o = words_q;
`endif

    assign fm_wr_en_o      = fm_wr_en_q;
    assign fm_wr_addr_o    = fm_wr_addr_q;
    assign fm_wr_data_o    = fm_wr_data_q;
    assign guard_wr_en_o   = guard_wr_en_q;
    assign guard_wr_addr_o = guard_wr_addr_q;
    assign guard_wr_data_o = guard_wr_data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign overflow_o      = ovf_q;
    assign overflow_row_o  = ovf_row_q;

endmodule

// File: tb/tb_fm_wb_collector.sv
module tb_fm_wb_collector;
    localparam int ROWS   = 2;
    localparam int PACK   = 4;
    localparam int ADDR_W = 12;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start_i;
    logic [ADDR_W-1:0]   fm_base_i, guard_base_i, row_stride_i;
    logic [ROWS*8-1:0]   wb_data_i;
    logic [ROWS-1:0]     wb_valid_i, wb_finish_i, guard_valid_i;
    logic [ROWS*6-1:0]   guard_i;
    logic                fm_wr_en_o, guard_wr_en_o, busy_o, done_o, overflow_o;
    logic [ADDR_W-1:0]   fm_wr_addr_o, guard_wr_addr_o;
    logic [PACK*8-1:0]   fm_wr_data_o;
    logic [5:0]          guard_wr_data_o;
    logic [ROWS-1:0]     overflow_row_o;
`ifdef FM_WB_PERF_CNT_EN
    logic [15:0]         stall_cnt_o, words_cnt_o;
`endif

    always #5 clk = ~clk;

    fm_wb_collector #(.ROWS(ROWS), .PACK(PACK), .FIFO_DEPTH(8), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .fm_base_i(fm_base_i), .guard_base_i(guard_base_i), .row_stride_i(row_stride_i),
        .wb_data_i(wb_data_i), .wb_valid_i(wb_valid_i), .wb_finish_i(wb_finish_i),
        .guard_i(guard_i), .guard_valid_i(guard_valid_i),
        .fm_wr_en_o(fm_wr_en_o), .fm_wr_addr_o(fm_wr_addr_o), .fm_wr_data_o(fm_wr_data_o),
        .guard_wr_en_o(guard_wr_en_o), .guard_wr_addr_o(guard_wr_addr_o),
        .guard_wr_data_o(guard_wr_data_o), .busy_o(busy_o), .done_o(done_o),
        .overflow_o(overflow_o), .overflow_row_o(overflow_row_o)
`ifdef FM_WB_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_o), .words_cnt_o(words_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ndone = 0;
    logic [ADDR_W-1:0] fa[$];
    logic [31:0]       fd[$];
    logic [ADDR_W-1:0] ga[$];
    logic [5:0]        gd[$];
    int                gt[$];

    always @(posedge clk) cyc++;

    // Write/done recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (fm_wr_en_o) begin
            fa.push_back(fm_wr_addr_o);
            fd.push_back(fm_wr_data_o);
        end
        if (guard_wr_en_o) begin
            ga.push_back(guard_wr_addr_o);
            gd.push_back(guard_wr_data_o);
            gt.push_back(cyc);
        end
        if (done_o) ndone++;
    end

    function automatic logic [31:0] fa_at(input int i);
        return (i < fa.size()) ? 32'(fa[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] fd_at(input int i);
        return (i < fd.size()) ? fd[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] ga_at(input int i);
        return (i < ga.size()) ? 32'(ga[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] gd_at(input int i);
        return (i < gd.size()) ? 32'(gd[i]) : 32'hFFFF_FFFF;
    endfunction
    function automatic int gt_at(input int i);
        return (i < gt.size()) ? gt[i] : -1000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clrq();
        fa.delete(); fd.delete(); ga.delete(); gd.delete(); gt.delete();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] fb, input logic [ADDR_W-1:0] gb,
                            input logic [ADDR_W-1:0] st);
        fm_base_i = fb; guard_base_i = gb; row_stride_i = st;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic finish_all();
        wb_finish_i = '1;
        tick();
        wb_finish_i = '0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0;
        int k;
        n0 = ndone;
        k  = 0;
        while (ndone == n0 && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 64'(ndone != n0), 64'd1);
        tick(); tick(); tick();
        chk({tag, "_done_once"}, 64'(ndone - n0), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        int n0;
        int r0;
        int r1;
        int inr;
        rst_n = 1'b0; start_i = 1'b0;
        fm_base_i = '0; guard_base_i = '0; row_stride_i = '0;
        wb_data_i = '0; wb_valid_i = '0; wb_finish_i = '0;
        guard_i = '0; guard_valid_i = '0;
        tick(); tick();
        chk("reset_ctrl", 64'({fm_wr_en_o, guard_wr_en_o, busy_o, done_o, overflow_o, overflow_row_o}), 64'd0);
        chk("reset_data", 64'({fm_wr_addr_o, fm_wr_data_o, guard_wr_addr_o, guard_wr_data_o}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Inputs in IDLE are ignored
        wb_valid_i = 2'b11; wb_data_i = 16'h5555; guard_valid_i = 2'b11;
        tick();
        wb_valid_i = '0; guard_valid_i = '0;
        tick(); tick(); tick();
        chk("idle_ignored", 64'({fm_wr_en_o, guard_wr_en_o, busy_o, overflow_o}), 64'd0);

        // T1: row 0 sends 01..08, both rows finish
        clrq();
        do_start(12'h100, 12'h200, 12'h040);
        chk("t1_busy", 64'(busy_o), 64'd1);
        for (int i = 0; i < 8; i++) begin
            wb_valid_i = 2'b01;
            wb_data_i  = {8'h00, 8'(i + 1)};
            tick();
        end
        wb_valid_i = '0;
        finish_all();
        wait_done("t1", 60);
        chk("t1_nwr", 64'(fa.size()), 64'd2);
        chk("t1_a0", 64'(fa_at(0)), 64'h100);
        chk("t1_d0", 64'(fd_at(0)), 64'h04030201);
        chk("t1_a1", 64'(fa_at(1)), 64'h101);
        chk("t1_d1", 64'(fd_at(1)), 64'h08070605);

        // T2: row 1 sends AA, BB, then CC together with finish
        clrq();
        do_start(12'h100, 12'h200, 12'h040);
        wb_valid_i = 2'b10; wb_data_i = 16'hAA00; tick();
        wb_data_i = 16'hBB00; tick();
        wb_data_i = 16'hCC00; wb_finish_i = 2'b11; tick();
        wb_valid_i = '0; wb_finish_i = '0;
        wait_done("t2", 60);
        chk("t2_nwr", 64'(fa.size()), 64'd1);
        chk("t2_a0", 64'(fa_at(0)), 64'h140);
        chk("t2_d0", 64'(fd_at(0)), 64'h00CCBBAA);

        // T4: both guards valid in the same cycle
        clrq();
        do_start(12'h100, 12'h200, 12'h040);
        guard_valid_i = 2'b11; guard_i = {6'h02, 6'h01};
        tick();
        guard_valid_i = '0;
        finish_all();
        wait_done("t4", 60);
        chk("t4_ngw", 64'(ga.size()), 64'd2);
        chk("t4_ga0", 64'(ga_at(0)), 64'h200);
        chk("t4_gd0", 64'(gd_at(0)), 64'h01);
        chk("t4_ga1", 64'(ga_at(1)), 64'h240);
        chk("t4_gd1", 64'(gd_at(1)), 64'h02);
        chk("t4_gap", 64'(gt_at(1) - gt_at(0)), 64'd1);
        chk("t4_noovf", 64'({overflow_o, overflow_row_o}), 64'd0);

        // T3: both rows push a word every cycle (byte + finish) for 20 cycles.
        // Row 0 is served on even drain slots, row 1 on odd; row 1 fills first
        // and loses 3 words, row 0 loses 2 -> 35 writes (18 + 17).
        clrq();
        do_start(12'h100, 12'h200, 12'h040);
        for (int i = 0; i < 20; i++) begin
            wb_valid_i = 2'b11; wb_finish_i = 2'b11;
            wb_data_i = {8'(8'h80 + i), 8'(i)};
            tick();
        end
        wb_valid_i = '0; wb_finish_i = '0;
        wait_done("t3", 200);
        r0 = 0; r1 = 0;
        foreach (fa[i]) begin
            if (fa[i] >= 12'h100 && fa[i] < 12'h140) r0++;
            else if (fa[i] >= 12'h140 && fa[i] < 12'h180) r1++;
        end
        chk("t3_nwr", 64'(fa.size()), 64'd35);
        chk("t3_row0", 64'(r0), 64'd18);
        chk("t3_row1", 64'(r1), 64'd17);
        chk("t3_a0", 64'(fa_at(0)), 64'h100);
        chk("t3_a1", 64'(fa_at(1)), 64'h140);
        chk("t3_a2", 64'(fa_at(2)), 64'h101);
        chk("t3_d1", 64'(fd_at(1)), 64'h00000080);
        chk("t3_d2", 64'(fd_at(2)), 64'h00000001);
        chk("t3_ovf_row", 64'(overflow_row_o), 64'h3);
        chk("t3_ovf", 64'(overflow_o), 64'd1);

        // T5: reset in the middle of a burst with words queued
        do_start(12'h100, 12'h200, 12'h040);
        for (int i = 0; i < 6; i++) begin
            wb_valid_i = 2'b11; wb_finish_i = 2'b11;
            wb_data_i = {8'(8'h90 + i), 8'(8'h10 + i)};
            tick();
        end
        rst_n = 1'b0;
        wb_valid_i = '0; wb_finish_i = '0;
        #1;
        clrq();
        chk("t5_rst_ctrl", 64'({fm_wr_en_o, guard_wr_en_o, busy_o, done_o, overflow_o, overflow_row_o}), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("t5_no_wr", 64'(fa.size()), 64'd0);
        chk("t5_busy", 64'(busy_o), 64'd0);
        do_start(12'h300, 12'h380, 12'h010);
        wb_valid_i = 2'b01; wb_data_i = 16'h005A; wb_finish_i = 2'b11;
        tick();
        wb_valid_i = '0; wb_finish_i = '0;
        wait_done("t5", 60);
        chk("t5_nwr", 64'(fa.size()), 64'd1);
        chk("t5_a0", 64'(fa_at(0)), 64'h300);
        chk("t5_d0", 64'(fd_at(0)), 64'h0000005A);

        // T6: start re-pulsed while draining is ignored
        clrq();
        n0 = ndone;
        do_start(12'h100, 12'h200, 12'h040);
        for (int i = 0; i < 10; i++) begin
            wb_valid_i = 2'b11; wb_finish_i = 2'b11;
            wb_data_i = {8'(8'hA0 + i), 8'(8'h20 + i)};
            fm_base_i = 12'h700; row_stride_i = 12'h008;
            start_i = (i == 5);
            tick();
        end
        start_i = 1'b0; wb_valid_i = '0; wb_finish_i = '0;
        wait_done("t6", 120);
        inr = 0;
        foreach (fa[i]) begin
            if ((fa[i] >= 12'h100 && fa[i] < 12'h10A) || (fa[i] >= 12'h140 && fa[i] < 12'h14A)) inr++;
        end
        chk("t6_nwr", 64'(fa.size()), 64'd20);
        chk("t6_inrange", 64'(inr), 64'd20);
        chk("t6_ndone", 64'(ndone - n0), 64'd1);
        chk("t6_noovf", 64'(overflow_o), 64'd0);

        // T7: guard arrives on both rows two cycles running; row 1 is not
        // granted in the second cycle, so its second guard is lost.
        clrq();
        do_start(12'h100, 12'h200, 12'h040);
        guard_valid_i = 2'b11; guard_i = {6'h11, 6'h01}; tick();
        guard_i = {6'h12, 6'h02}; tick();
        guard_valid_i = '0;
        finish_all();
        wait_done("t7", 60);
        chk("t7_ngw", 64'(ga.size()), 64'd3);
        chk("t7_w0", 64'({ga_at(0), gd_at(0)}), {32'h200, 32'h01});
        chk("t7_w1", 64'({ga_at(1), gd_at(1)}), {32'h240, 32'h11});
        chk("t7_w2", 64'({ga_at(2), gd_at(2)}), {32'h201, 32'h02});
        chk("t7_ovf_row", 64'(overflow_row_o), 64'h2);
        chk("t7_ovf", 64'(overflow_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
